// File: rtl/polar_pkg.sv
// Shared definitions for the SCL decoder: list/width parameters, pm_extend state
// encoding, and path-metric helper functions.
package polar_pkg;

    localparam int LIST_SIZE   = 4;
    localparam int PM_WIDTH    = 8;
    localparam int INDEX_WIDTH = 3;
    localparam int LLR_WIDTH   = 6;

    localparam int NUM_CAND   = 2 * LIST_SIZE;
    localparam int CAND_WIDTH = PM_WIDTH + INDEX_WIDTH;
    localparam int PM_VEC_W   = LIST_SIZE * PM_WIDTH;
    localparam int LLR_VEC_W  = LIST_SIZE * LLR_WIDTH;
    localparam int CAND_VEC_W = NUM_CAND * CAND_WIDTH;

    localparam logic [PM_WIDTH-1:0] PM_MAX = {PM_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_OUT       = 2'd1,
        ST_WAIT_SURV = 2'd2
    } pm_state_e;

    // Only path 0 starts as a live path; the others start at the worst metric.
    function automatic logic [PM_VEC_W-1:0] pm_init_vec();
        logic [PM_VEC_W-1:0] v;
        v = {PM_VEC_W{1'b1}};
        v[PM_WIDTH-1:0] = {PM_WIDTH{1'b0}};
        return v;
    endfunction

    // When every metric has its MSB set, dropping the MSB keeps the ordering intact.
    function automatic logic [PM_VEC_W-1:0] pm_normalise(input logic [PM_VEC_W-1:0] pms);
        logic [PM_VEC_W-1:0] v;
        logic                all_msb;
        v       = pms;
        all_msb = 1'b1;
        for (int p = 0; p < LIST_SIZE; p++) begin
            all_msb = all_msb & pms[p*PM_WIDTH + PM_WIDTH - 1];
        end
        if (all_msb) begin
            for (int p = 0; p < LIST_SIZE; p++) begin
                v[p*PM_WIDTH + PM_WIDTH - 1] = 1'b0;
            end
        end else begin
            v = pms;
        end
        return v;
    endfunction

endpackage

// File: rtl/pm_sat_add.sv
// One candidate metric: adds |llr| to the path metric when the hypothesised bit
// disagrees with the LLR sign, saturating at PM_MAX.
module pm_sat_add
    import polar_pkg::*;
(
    input  logic [PM_WIDTH-1:0]  i_pm,
    input  logic [LLR_WIDTH-1:0] i_llr,
    input  logic                 i_bit,
    output logic [PM_WIDTH-1:0]  o_pm
);

    logic                w_neg;
    logic [PM_WIDTH-1:0] w_llr_ext;
    logic [PM_WIDTH-1:0] w_abs;
    logic [PM_WIDTH-1:0] w_pen;
    logic [PM_WIDTH:0]   w_sum;

    // Magnitude is taken at PM width so the most negative LLR stays representable.
    always_comb begin
        w_neg     = i_llr[LLR_WIDTH-1];
        w_llr_ext = PM_WIDTH'($signed(i_llr));
        if (w_neg) begin
            w_abs = {PM_WIDTH{1'b0}} - w_llr_ext;
        end else begin
            w_abs = w_llr_ext;
        end
        if (w_neg ^ i_bit) begin
            w_pen = w_abs;
        end else begin
            w_pen = {PM_WIDTH{1'b0}};
        end
        w_sum = {1'b0, i_pm} + {1'b0, w_pen};
        if (w_sum[PM_WIDTH]) begin
            o_pm = PM_MAX;
        end else begin
            o_pm = w_sum[PM_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pm_extend.sv
// Path-metric extension stage: expands L path metrics into 2L tagged candidates
// for the sorter, absorbs frozen bits locally and reloads survivor metrics.
module pm_extend
    import polar_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_start,
    input  logic                  llr_valid,
    output logic                  llr_ready,
    input  logic [LLR_VEC_W-1:0]  llr_in,
    input  logic                  frozen,
    output logic                  cand_valid,
    input  logic                  cand_ready,
    output logic [CAND_VEC_W-1:0] cand_out,
    input  logic                  surv_valid,
    input  logic [PM_VEC_W-1:0]   surv_pm
);

    pm_state_e             r_state;
    pm_state_e             w_state_next;
    logic [PM_VEC_W-1:0]   r_pm;
    logic [PM_VEC_W-1:0]   w_pm_next;
    logic [PM_VEC_W-1:0]   w_frozen_pm;
    logic [CAND_VEC_W-1:0] r_cand;
    logic [CAND_VEC_W-1:0] w_cand;
    logic                  w_pm_load;
    logic                  w_cand_load;

    for (genvar k = 0; k < NUM_CAND; k++) begin : g_cand
        logic [PM_WIDTH-1:0] w_sum_pm;

        pm_sat_add u_add (
            .i_pm  (r_pm[(k/2)*PM_WIDTH +: PM_WIDTH]),
            .i_llr (llr_in[(k/2)*LLR_WIDTH +: LLR_WIDTH]),
            .i_bit (1'((k % 2))),
            .o_pm  (w_sum_pm)
        );

        assign w_cand[k*CAND_WIDTH +: CAND_WIDTH] = {INDEX_WIDTH'(k), w_sum_pm};

        // A frozen bit is always 0, so each path keeps its b=0 candidate.
        if ((k % 2) == 0) begin : g_even
            assign w_frozen_pm[(k/2)*PM_WIDTH +: PM_WIDTH] = w_sum_pm;
        end
    end

    // Next-state and PM/candidate load decisions; dec_start overrides everything.
    always_comb begin
        w_state_next = r_state;
        w_pm_next    = r_pm;
        w_pm_load    = 1'b0;
        w_cand_load  = 1'b0;
        if (dec_start) begin
            w_state_next = ST_IDLE;
            w_pm_next    = pm_init_vec();
            w_pm_load    = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (llr_valid && frozen) begin
                        w_pm_next = pm_normalise(w_frozen_pm);
                        w_pm_load = 1'b1;
                    end else if (llr_valid) begin
                        w_cand_load  = 1'b1;
                        w_state_next = ST_OUT;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_OUT: begin
                    if (cand_ready) begin
                        w_state_next = ST_WAIT_SURV;
                    end else begin
                        w_state_next = ST_OUT;
                    end
                end
                ST_WAIT_SURV: begin
                    if (surv_valid) begin
                        w_pm_next    = pm_normalise(surv_pm);
                        w_pm_load    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_WAIT_SURV;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Path-metric register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pm <= pm_init_vec();
        end else if (w_pm_load) begin
            r_pm <= w_pm_next;
        end
    end

    // Candidate register, held stable while the sorter back-pressures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand <= {CAND_VEC_W{1'b0}};
        end else if (w_cand_load) begin
            r_cand <= w_cand;
        end
    end

    assign cand_out   = r_cand;
    assign llr_ready  = (r_state == ST_IDLE);
    assign cand_valid = (r_state == ST_OUT);

endmodule

// File: tb/tb_pm_extend.sv
// Randomised scoreboard bench for pm_extend against an arithmetic path-metric model.
module tb_pm_extend;
    import polar_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  dec_start = 1'b0;
    logic                  llr_valid = 1'b0;
    logic                  llr_ready;
    logic [LLR_VEC_W-1:0]  llr_in = '0;
    logic                  frozen = 1'b0;
    logic                  cand_valid;
    logic                  cand_ready = 1'b0;
    logic [CAND_VEC_W-1:0] cand_out;
    logic                  surv_valid = 1'b0;
    logic [PM_VEC_W-1:0]   surv_pm = '0;

    pm_extend dut (
        .clk        (clk),
        .rst        (rst),
        .dec_start  (dec_start),
        .llr_valid  (llr_valid),
        .llr_ready  (llr_ready),
        .llr_in     (llr_in),
        .frozen     (frozen),
        .cand_valid (cand_valid),
        .cand_ready (cand_ready),
        .cand_out   (cand_out),
        .surv_valid (surv_valid),
        .surv_pm    (surv_pm)
    );

    always #5 clk = ~clk;

    localparam int PMAX = (1 << PM_WIDTH) - 1;
    localparam int HALF = 1 << (PM_WIDTH - 1);

    int checks   = 0;
    int failures = 0;
    int m_pm   [LIST_SIZE];
    int v_llr  [LIST_SIZE];
    int v_surv [LIST_SIZE];
    logic [CAND_VEC_W-1:0] sb_q [$];

    task automatic chk(input string name, input logic [CAND_VEC_W-1:0] act,
                       input logic [CAND_VEC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_init();
        m_pm[0] = 0;
        for (int p = 1; p < LIST_SIZE; p++) m_pm[p] = PMAX;
    endfunction

    function automatic void model_norm();
        bit all_big = 1'b1;
        for (int p = 0; p < LIST_SIZE; p++) if (m_pm[p] < HALF) all_big = 1'b0;
        if (all_big) for (int p = 0; p < LIST_SIZE; p++) m_pm[p] = m_pm[p] - HALF;
    endfunction

    function automatic int cand_pm(input int pm, input int llr, input int b);
        int pen = (llr < 0) ? -llr : llr;
        int s   = pm;
        if ((b == 0 && llr < 0) || (b == 1 && llr >= 0)) s = pm + pen;
        return (s > PMAX) ? PMAX : s;
    endfunction

    function automatic logic [CAND_VEC_W-1:0] expected_cands();
        logic [CAND_VEC_W-1:0] v;
        for (int k = 0; k < NUM_CAND; k++)
            v[k*CAND_WIDTH +: CAND_WIDTH] = {INDEX_WIDTH'(k), PM_WIDTH'(cand_pm(m_pm[k/2], v_llr[k/2], k % 2))};
        return v;
    endfunction

    task automatic set_llr(input int l3, input int l2, input int l1, input int l0);
        v_llr[3] = l3; v_llr[2] = l2; v_llr[1] = l1; v_llr[0] = l0;
    endtask

    task automatic set_surv(input int s3, input int s2, input int s1, input int s0);
        v_surv[3] = s3; v_surv[2] = s2; v_surv[1] = s1; v_surv[0] = s0;
    endtask

    task automatic send_vec(input bit frz);
        int waited = 0;
        while (!llr_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk("llr_ready_before_send", CAND_VEC_W'(llr_ready), CAND_VEC_W'(1));
        for (int p = 0; p < LIST_SIZE; p++) llr_in[p*LLR_WIDTH +: LLR_WIDTH] = LLR_WIDTH'(v_llr[p]);
        frozen    = frz;
        llr_valid = 1'b1;
        if (!frz) sb_q.push_back(expected_cands());
        tick();
        llr_valid = 1'b0;
        frozen    = 1'b0;
        if (frz) begin
            for (int p = 0; p < LIST_SIZE; p++) m_pm[p] = cand_pm(m_pm[p], v_llr[p], 0);
            model_norm();
            chk("llr_ready_after_frozen", CAND_VEC_W'(llr_ready), CAND_VEC_W'(1));
        end
    endtask

    task automatic finish_info(input int hold, input bit do_surv);
        for (int i = 0; i < hold; i++) begin
            chk("hold_cand_valid", CAND_VEC_W'(cand_valid), CAND_VEC_W'(1));
            chk("hold_llr_ready", CAND_VEC_W'(llr_ready), CAND_VEC_W'(0));
            tick();
        end
        chk("cand_valid_pre_hs", CAND_VEC_W'(cand_valid), CAND_VEC_W'(1));
        cand_ready = 1'b1;
        tick();
        cand_ready = 1'b0;
        chk("wait_surv_cand_valid", CAND_VEC_W'(cand_valid), CAND_VEC_W'(0));
        chk("wait_surv_llr_ready", CAND_VEC_W'(llr_ready), CAND_VEC_W'(0));
        if (do_surv) begin
            for (int p = 0; p < LIST_SIZE; p++) surv_pm[p*PM_WIDTH +: PM_WIDTH] = PM_WIDTH'(v_surv[p]);
            surv_valid = 1'b1;
            tick();
            surv_valid = 1'b0;
            for (int p = 0; p < LIST_SIZE; p++) m_pm[p] = v_surv[p];
            model_norm();
            chk("llr_ready_after_surv", CAND_VEC_W'(llr_ready), CAND_VEC_W'(1));
        end
    endtask

    // Zero LLRs make every candidate equal to its path metric.
    task automatic reveal();
        set_llr(0, 0, 0, 0);
        send_vec(1'b0);
        set_surv($urandom_range(0, PMAX), $urandom_range(0, PMAX), $urandom_range(0, PMAX), $urandom_range(0, PMAX));
        finish_info(0, 1'b1);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst && cand_valid) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL cand_unexpected: got %h expected none at %0t", cand_out, $time);
                    end else begin
                        chk("cand_out", cand_out, sb_q[0]);
                        if (cand_ready) void'(sb_q.pop_front());
                    end
                end
            end
            begin
                #500000;
                $display("FAIL timeout: got running expected finished");
                $fatal(1, "timeout");
            end
        join_none

        model_init();
        repeat (3) tick();
        chk("reset_llr_ready", CAND_VEC_W'(llr_ready), CAND_VEC_W'(1));
        chk("reset_cand_valid", CAND_VEC_W'(cand_valid), CAND_VEC_W'(0));
        chk("reset_cand_out", cand_out, '0);
        rst = 1'b0;
        tick();
        dec_start = 1'b1;
        tick();
        dec_start = 1'b0;

        set_llr(3, -5, 0, 7);
        send_vec(1'b0);
        set_surv(200, 150, 140, 130);
        finish_info(5, 1'b1);
        reveal();

        set_surv(200, 150, 140, 110);
        set_llr(0, 0, 0, 0);
        send_vec(1'b0);
        finish_info(0, 1'b1);
        set_llr(-20, -20, -20, -20);
        send_vec(1'b1);
        set_llr(-3, 9, -1, 4);
        send_vec(1'b1);
        reveal();

        set_llr(0, 0, 0, 0);
        send_vec(1'b0);
        set_surv(30, 20, 10, 240);
        finish_info(0, 1'b1);
        set_llr(5, -7, 1, -32);
        send_vec(1'b0);
        finish_info(1, 1'b1);

        set_llr(11, -2, 8, -9);
        send_vec(1'b0);
        tick();
        cand_ready = 1'b1;
        dec_start  = 1'b1;
        tick();
        cand_ready = 1'b0;
        dec_start  = 1'b0;
        chk("dec_start_cand_valid", CAND_VEC_W'(cand_valid), CAND_VEC_W'(0));
        chk("dec_start_llr_ready", CAND_VEC_W'(llr_ready), CAND_VEC_W'(1));
        sb_q.delete();
        model_init();
        reveal();

        for (int p = 0; p < LIST_SIZE; p++) surv_pm[p*PM_WIDTH +: PM_WIDTH] = PM_WIDTH'($urandom_range(0, PMAX));
        surv_valid = 1'b1;
        tick();
        surv_valid = 1'b0;
        reveal();

        for (int it = 0; it < 60; it++) begin
            for (int p = 0; p < LIST_SIZE; p++) v_llr[p] = int'($urandom_range(0, 63)) - 32;
            if ($urandom_range(0, 9) < 3) begin
                send_vec(1'b1);
            end else begin
                send_vec(1'b0);
                for (int p = 0; p < LIST_SIZE; p++) v_surv[p] = $urandom_range(0, PMAX);
                if ($urandom_range(0, 3) == 0)
                    for (int p = 0; p < LIST_SIZE; p++) v_surv[p] = $urandom_range(HALF, PMAX);
                finish_info($urandom_range(0, 3), 1'b1);
            end
        end

        set_llr(6, 6, 6, 6);
        send_vec(1'b0);
        finish_info(0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_llr_ready", CAND_VEC_W'(llr_ready), CAND_VEC_W'(1));
        chk("async_rst_cand_valid", CAND_VEC_W'(cand_valid), CAND_VEC_W'(0));
        chk("async_rst_cand_out", cand_out, '0);
        sb_q.delete();
        model_init();
        tick();
        rst = 1'b0;
        tick();
        reveal();

        repeat (2) tick();
        chk("scoreboard_drained", CAND_VEC_W'(sb_q.size()), CAND_VEC_W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
